// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button debounce, run/pause/done FSM,
// count enable/clear generation and lap-snapshot display mux.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk_count,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_lap,
  input  logic        btn_clr,
  input  logic        target_en,
  input  logic [15:0] target,
  input  logic [3:0]  c0,
  input  logic [3:0]  c1,
  input  logic [3:0]  c2,
  input  logic [3:0]  c3,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic [3:0]  disp0,
  output logic [3:0]  disp1,
  output logic [3:0]  disp2,
  output logic [3:0]  disp3,
  output logic        lap_active,
  output logic        done,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_LAP   = 2;
  localparam int B_CLR   = 3;

  localparam logic [7:0] DB_M1 = 8'(DEBOUNCE - 1);

  logic [3:0]      raw;
  logic [3:0]      sync1_q;
  logic [3:0]      sync2_q;
  logic [3:0][7:0] stab_q;
  logic [3:0][7:0] stab_d;
  logic [3:0]      press_q;
  logic [3:0]      press_d;

  assign raw = {btn_clr, btn_lap, btn_stop, btn_start};

  // Press also needs the first-stage sample high, so a level must be
  // seen for DEBOUNCE+1 raw samples before it is accepted.
  always_comb begin
    stab_d  = '0;
    press_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i]) begin
        if (stab_q[i] == 8'hFF) begin
          stab_d[i] = stab_q[i];
        end else begin
          stab_d[i] = stab_q[i] + 8'd1;
        end
      end
      press_d[i] = sync2_q[i] & sync1_q[i]
                 & (stab_q[i] == DB_M1);
    end
  end

  always_ff @(posedge clk_count or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stab_q  <= '0;
      press_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stab_q  <= stab_d;
      press_q <= press_d;
    end
  end

  state_e      state_q;
  state_e      state_d;
  logic        lap_act_q;
  logic        lap_act_d;
  logic [15:0] lap_q;
  logic [15:0] lap_d;
  logic        clr_q;
  logic        clr_d;

  logic [15:0] live;
  logic        hit;
  logic        pr_clr;
  logic        pr_stop;
  logic        pr_start;
  logic        pr_lap;

  assign live = {c3, c2, c1, c0};
  assign hit  = target_en & (live == target);

  // Only the highest-priority press of a cycle is acted on.
  assign pr_clr   = press_q[B_CLR];
  assign pr_stop  = press_q[B_STOP] & ~pr_clr;
  assign pr_start = press_q[B_START] & ~press_q[B_STOP] & ~pr_clr;
  assign pr_lap   = press_q[B_LAP] & ~press_q[B_START]
                  & ~press_q[B_STOP] & ~pr_clr;

  always_comb begin
    state_d   = state_q;
    lap_act_d = lap_act_q;
    lap_d     = lap_q;
    clr_d     = 1'b0;
    if (pr_clr) begin
      state_d   = S_IDLE;
      lap_act_d = 1'b0;
      clr_d     = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pr_start) begin
            state_d = S_RUN;
          end else if (pr_lap) begin
            lap_act_d = 1'b0;
          end
        end
        S_RUN: begin
          if (pr_stop) begin
            state_d = S_PAUSE;
          end else if (hit) begin
            state_d = S_DONE;
          end
          if (pr_lap) begin
            if (lap_act_q) begin
              lap_act_d = 1'b0;
            end else begin
              lap_act_d = 1'b1;
              lap_d     = live;
            end
          end
        end
        S_PAUSE: begin
          if (pr_start) begin
            state_d = S_RUN;
          end else if (pr_lap) begin
            lap_act_d = 1'b0;
          end
        end
        S_DONE: begin
          if (pr_lap) begin
            lap_act_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_count or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lap_act_q <= 1'b0;
      lap_q     <= '0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_act_q <= lap_act_d;
      lap_q     <= lap_d;
      clr_q     <= clr_d;
    end
  end

  // Enable drops combinationally on the target so the counter never overshoots.
  assign cnt_en     = (state_q == S_RUN) & ~hit;
  assign cnt_clr    = clr_q;
  assign done       = (state_q == S_DONE);
  assign state      = state_q;
  assign lap_active = lap_act_q;

  assign disp0 = lap_act_q ? lap_q[3:0]   : c0;
  assign disp1 = lap_act_q ? lap_q[7:4]   : c1;
  assign disp2 = lap_act_q ? lap_q[11:8]  : c2;
  assign disp3 = lap_act_q ? lap_q[15:12] : c3;

endmodule
